// File: rtl/midi_pkg.sv
// Shared constants, message types, parser state encoding and decode helpers
// for the MIDI channel-voice message parser.
package midi_pkg;

  localparam logic [7:0] ST_NOTE_OFF   = 8'h80;
  localparam logic [7:0] ST_PROG_CHG   = 8'hC0;
  localparam logic [7:0] ST_PITCH_BEND = 8'hE0;
  localparam logic [7:0] ST_SYS_COMMON = 8'hF0;
  localparam logic [7:0] ST_EOX        = 8'hF7;
  localparam logic [7:0] ST_REALTIME   = 8'hF8;

  localparam logic [2:0] MT_NOTE_OFF       = 3'd0;
  localparam logic [2:0] MT_NOTE_ON        = 3'd1;
  localparam logic [2:0] MT_POLY_AT        = 3'd2;
  localparam logic [2:0] MT_CONTROL_CHANGE = 3'd3;
  localparam logic [2:0] MT_PROGRAM_CHANGE = 3'd4;
  localparam logic [2:0] MT_CHANNEL_AT     = 3'd5;
  localparam logic [2:0] MT_PITCH_BEND     = 3'd6;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_D1 = 2'd1;
  localparam logic [1:0] S_WAIT_D2 = 2'd2;
  localparam logic [1:0] S_SKIP    = 2'd3;

  typedef struct packed {
    logic [2:0] msg_type;
    logic [3:0] chan;
    logic [6:0] data1;
    logic [6:0] data2;
  } midi_msg_t;

  // Program change and channel aftertouch carry one data byte, the rest two.
  function automatic logic [1:0] data_count(input logic [7:0] status);
    return (status >= ST_PROG_CHG && status < ST_PITCH_BEND) ? 2'd1 : 2'd2;
  endfunction

  // Status 0x8n..0xEn maps to type 0..6; note-on with velocity 0 is a note-off.
  function automatic logic [2:0] msg_type_of(input logic [7:0] status, input logic [6:0] d2);
    logic [2:0] t;
    t = status[6:4];
    if (t == MT_NOTE_ON && d2 == 7'd0) t = MT_NOTE_OFF;
    return t;
  endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Output message channel of the parser.
// Handshake: a transfer happens on every clk edge where msg_valid & msg_ready;
// the producer holds msg_* stable while msg_valid=1 and the transfer has not happened.
interface midi_msg_parser_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [2:0] msg_type;
  logic [3:0] msg_chan;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;

  modport master (
    output msg_valid, msg_type, msg_chan, msg_data1, msg_data2,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_type, msg_chan, msg_data1, msg_data2,
    output msg_ready
  );
endinterface

// File: rtl/midi_msg_outreg.sv
// One-entry valid/ready holding register for finished messages; a message
// completing while the register is full and not being accepted is dropped.
module midi_msg_outreg
  import midi_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  midi_msg_t load_msg,
  output logic      overrun,
  midi_msg_parser_if.master msg
);

  logic      valid_q;
  midi_msg_t msg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      msg_q   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && valid_q && !msg.msg_ready;
      if (load && (!valid_q || msg.msg_ready)) begin
        valid_q <= 1'b1;
        msg_q   <= load_msg;
      end else if (valid_q && msg.msg_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign msg.msg_valid = valid_q;
  assign msg.msg_type  = msg_q.msg_type;
  assign msg.msg_chan  = msg_q.chan;
  assign msg.msg_data1 = msg_q.data1;
  assign msg.msg_data2 = msg_q.data2;

endmodule

// File: rtl/midi_msg_parser.sv
// Frames received MIDI bytes into channel-voice messages: running status,
// data-byte counting, channel filtering, SysEx/system-common dropping.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter logic       OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  midi_msg_parser_if.master msg,
  output logic       err,
  output logic       overrun,
  output logic [1:0] state_dbg
);

  logic [1:0] state, state_n;
  logic [7:0] run_status, run_status_n;
  logic       fresh, fresh_n;
  logic [6:0] data1, data1_n;
  logic       err_n;
  logic       complete;
  logic [6:0] comp_d1, comp_d2;
  logic       is_rt, is_sys, is_chan;
  logic       load;
  midi_msg_t  load_msg;

  assign is_rt   = byte_in >= ST_REALTIME;
  assign is_sys  = byte_in >= ST_SYS_COMMON && !is_rt;
  assign is_chan = byte_in[7] && byte_in < ST_SYS_COMMON;

  // fresh: a status byte was loaded and no data byte has followed it yet.
  always_comb begin
    state_n      = state;
    run_status_n = run_status;
    fresh_n      = fresh;
    data1_n      = data1;
    err_n        = 1'b0;
    complete     = 1'b0;
    comp_d1      = 7'd0;
    comp_d2      = 7'd0;
    if (byte_valid && !is_rt) begin
      if (is_chan) begin
        err_n        = (state == S_WAIT_D2) || (state == S_WAIT_D1 && fresh);
        run_status_n = byte_in;
        fresh_n      = 1'b1;
        state_n      = S_WAIT_D1;
      end else if (is_sys) begin
        // EOX closes the SysEx, so following data is stray rather than skipped.
        run_status_n = 8'h00;
        fresh_n      = 1'b0;
        state_n      = (byte_in == ST_EOX) ? S_IDLE : S_SKIP;
      end else begin
        case (state)
          S_IDLE: err_n = 1'b1;
          S_WAIT_D1: begin
            fresh_n = 1'b0;
            if (data_count(run_status) == 2'd1) begin
              complete = 1'b1;
              comp_d1  = byte_in[6:0];
            end else begin
              data1_n = byte_in[6:0];
              state_n = S_WAIT_D2;
            end
          end
          S_WAIT_D2: begin
            complete = 1'b1;
            comp_d1  = data1;
            comp_d2  = byte_in[6:0];
            state_n  = S_WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      run_status <= 8'h00;
      fresh      <= 1'b0;
      data1      <= 7'd0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      run_status <= run_status_n;
      fresh      <= fresh_n;
      data1      <= data1_n;
      err        <= err_n;
    end
  end

  assign load              = complete && (OMNI || run_status[3:0] == CHANNEL);
  assign load_msg.msg_type = msg_type_of(run_status, comp_d2);
  assign load_msg.chan     = run_status[3:0];
  assign load_msg.data1    = comp_d1;
  assign load_msg.data2    = comp_d2;
  assign state_dbg         = state;

  midi_msg_outreg u_outreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_msg (load_msg),
    .overrun  (overrun),
    .msg      (msg)
  );

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: two instances (channel 0 and channel 2) against a
// byte-stream level model, plus directed checks of accepted message lists.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       msg_ready = 1'b0;
  logic       err0, ovr0, err2, ovr2;
  logic [1:0] st0, st2;
  bit         cmp_en = 1'b0;

  int tests = 0;
  int failed = 0;
  int err_cnt0 = 0, err_cnt2 = 0, ovr_cnt0 = 0, ovr_cnt2 = 0;
  logic [20:0] got0[$];
  logic [20:0] got2[$];

  always #5 clk = ~clk;

  midi_msg_parser_if if0();
  midi_msg_parser_if if2();
  assign if0.msg_ready = msg_ready;
  assign if2.msg_ready = msg_ready;

  midi_msg_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg(if0), .err(err0), .overrun(ovr0), .state_dbg(st0)
  );

  midi_msg_parser #(.CHANNEL(4'd2), .OMNI(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg(if2), .err(err2), .overrun(ovr2), .state_dbg(st2)
  );

  // ---------------- model ----------------
  typedef struct {
    logic [7:0]  status;
    bit          skip;
    bit          fresh;
    int          cnt;
    logic [6:0]  d1;
    bit          valid;
    logic [20:0] msg;
    bit          err;
    bit          ovr;
  } model_t;

  model_t m0, m2;

  function automatic void model_reset(inout model_t m);
    m.status = 8'h00; m.skip = 0; m.fresh = 0; m.cnt = 0; m.d1 = 7'd0;
    m.valid = 0; m.msg = 21'd0; m.err = 0; m.ovr = 0;
  endfunction

  function automatic void model_step(inout model_t m, input logic bv, input logic [7:0] b,
                                     input logic rdy, input logic [3:0] cfg);
    bit         complete = 0;
    bit         accept;
    int         need;
    logic [6:0] d1 = 7'd0;
    logic [6:0] d2 = 7'd0;
    logic [2:0] t = 3'd0;
    accept = m.valid && rdy;
    m.err = 0;
    m.ovr = 0;
    if (bv) begin
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
        m.status = 8'h00; m.cnt = 0; m.fresh = 0; m.skip = (b != 8'hF7);
      end else if (b >= 8'h80) begin
        m.err = (m.cnt != 0) || m.fresh;
        m.status = b; m.cnt = 0; m.fresh = 1; m.skip = 0;
      end else if (m.skip) begin
      end else if (m.status == 8'h00) begin
        m.err = 1;
      end else begin
        m.fresh = 0;
        if (m.cnt == 0) m.d1 = b[6:0];
        m.cnt++;
        need = (m.status[7:4] == 4'hC || m.status[7:4] == 4'hD) ? 1 : 2;
        if (m.cnt == need) begin
          complete = 1;
          d1 = m.d1;
          d2 = (need == 2) ? b[6:0] : 7'd0;
          m.cnt = 0;
        end
      end
    end
    if (complete) begin
      case (m.status[7:4])
        4'h8: t = 3'd0;
        4'h9: t = (d2 == 7'd0) ? 3'd0 : 3'd1;
        4'hA: t = 3'd2;
        4'hB: t = 3'd3;
        4'hC: t = 3'd4;
        4'hD: t = 3'd5;
        default: t = 3'd6;
      endcase
    end
    if (complete && m.status[3:0] == cfg) begin
      if (m.valid && !rdy) m.ovr = 1;
      else begin
        m.valid = 1;
        m.msg = {t, m.status[3:0], d1, d2};
      end
    end else if (accept) begin
      m.valid = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(m0);
      model_reset(m2);
    end else begin
      model_step(m0, byte_valid, byte_in, msg_ready, 4'd0);
      model_step(m2, byte_valid, byte_in, msg_ready, 4'd2);
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] t, input logic [3:0] c,
                                     input logic [6:0] d1, input logic [6:0] d2);
    return {11'd0, t, c, d1, d2};
  endfunction

  task automatic check_got(input string name, input int inst, input int idx, input logic [31:0] exp);
    logic [31:0] act;
    act = 32'hDEAD_BEEF;
    if (inst == 0 && idx < got0.size()) act = {11'd0, got0[idx]};
    if (inst == 2 && idx < got2.size()) act = {11'd0, got2[idx]};
    check(name, act, exp);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_dut0", {8'd0, if0.msg_valid, if0.msg_type, if0.msg_chan, if0.msg_data1,
                           if0.msg_data2, err0, ovr0}, {8'd0, m0.valid, m0.msg, m0.err, m0.ovr});
      check("cycle_dut2", {8'd0, if2.msg_valid, if2.msg_type, if2.msg_chan, if2.msg_data1,
                           if2.msg_data2, err2, ovr2}, {8'd0, m2.valid, m2.msg, m2.err, m2.ovr});
      if (err0) err_cnt0++;
      if (err2) err_cnt2++;
      if (ovr0) ovr_cnt0++;
      if (ovr2) ovr_cnt2++;
    end
  end

  always @(posedge clk) begin
    if (rst_n && msg_ready && if0.msg_valid)
      got0.push_back({if0.msg_type, if0.msg_chan, if0.msg_data1, if0.msg_data2});
    if (rst_n && msg_ready && if2.msg_valid)
      got2.push_back({if2.msg_type, if2.msg_chan, if2.msg_data1, if2.msg_data2});
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  int s0, s2, e0, e2, o0, o2;

  task automatic snap();
    s0 = got0.size(); s2 = got2.size();
    e0 = err_cnt0; e2 = err_cnt2; o0 = ovr_cnt0; o2 = ovr_cnt2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(posedge clk); #1;
    cmp_en = 1'b1;
    idle(2);
    check("reset_out0", {if0.msg_valid, if0.msg_type, if0.msg_chan, if0.msg_data1, if0.msg_data2, err0, ovr0}, 0);
    check("reset_out2", {if2.msg_valid, if2.msg_type, if2.msg_chan, if2.msg_data1, if2.msg_data2, err2, ovr2}, 0);
    check("reset_state0", {30'd0, st0}, 0);
    rst_n = 1'b1;
    msg_ready = 1'b1;
    idle(2);

    // Single note-on
    snap();
    send(8'h90); send(8'h3C); send(8'h64); idle(3);
    check("t1_count", got0.size() - s0, 1);
    check_got("t1_msg", 0, s0, mk(3'd1, 4'd0, 7'h3C, 7'h64));
    check("t1_err", err_cnt0 - e0, 0);

    // Running status, velocity-0 note-on becomes note-off
    snap();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h00); idle(3);
    check("t2_count", got0.size() - s0, 2);
    check_got("t2_msg0", 0, s0, mk(3'd1, 4'd0, 7'h3C, 7'h64));
    check_got("t2_msg1", 0, s0 + 1, mk(3'd0, 4'd0, 7'h3E, 7'h00));

    // Real-time byte inside a control change
    snap();
    send(8'hB0); send(8'h07); send(8'hF8); send(8'h7F); idle(3);
    check("t3_count", got0.size() - s0, 1);
    check_got("t3_msg", 0, s0, mk(3'd3, 4'd0, 7'h07, 7'h7F));
    check("t3_err", err_cnt0 - e0, 0);

    // SysEx dropped, stray data after EOX flagged
    snap();
    send(8'hF0); send(8'h41); send(8'h10); send(8'hF7); send(8'h3C); idle(3);
    check("t4_count", got0.size() - s0, 0);
    check("t4_err", err_cnt0 - e0, 1);

    // Overrun while the output register is held
    msg_ready = 1'b0;
    snap();
    send(8'hC0); send(8'h05); send(8'hC0); send(8'h06); idle(2);
    check("t5_held_valid", {31'd0, if0.msg_valid}, 1);
    check("t5_held_msg", {11'd0, if0.msg_type, if0.msg_chan, if0.msg_data1, if0.msg_data2},
          mk(3'd4, 4'd0, 7'h05, 7'h00));
    check("t5_ovr0", ovr_cnt0 - o0, 1);
    check("t5_ovr2", ovr_cnt2 - o2, 0);
    msg_ready = 1'b1;
    idle(1);
    check("t5_valid_fall", {31'd0, if0.msg_valid}, 0);
    check("t5_count", got0.size() - s0, 1);
    check_got("t5_msg", 0, s0, mk(3'd4, 4'd0, 7'h05, 7'h00));
    idle(2);

    // Aborted messages and the remaining message types
    snap();
    send(8'h90); send(8'h90); send(8'h40); send(8'h40);
    send(8'h90); send(8'h3C); send(8'h80); send(8'h40); send(8'h00);
    send(8'hA0); send(8'h10); send(8'h20); send(8'hD0); send(8'h7F);
    send(8'hE0); send(8'h01); send(8'h02); idle(3);
    check("t7_err", err_cnt0 - e0, 2);
    check("t7_count", got0.size() - s0, 5);
    check_got("t7_msg0", 0, s0, mk(3'd1, 4'd0, 7'h40, 7'h40));
    check_got("t7_msg1", 0, s0 + 1, mk(3'd0, 4'd0, 7'h40, 7'h00));
    check_got("t7_msg2", 0, s0 + 2, mk(3'd2, 4'd0, 7'h10, 7'h20));
    check_got("t7_msg3", 0, s0 + 3, mk(3'd5, 4'd0, 7'h7F, 7'h00));
    check_got("t7_msg4", 0, s0 + 4, mk(3'd6, 4'd0, 7'h01, 7'h02));

    // Channel filter, then reset with a held message and a partial one
    snap();
    send(8'h91); send(8'h40); send(8'h40); send(8'h92); send(8'h40); send(8'h40); idle(3);
    check("t6_count0", got0.size() - s0, 0);
    check("t6_count2", got2.size() - s2, 1);
    check_got("t6_msg2", 2, s2, mk(3'd1, 4'd2, 7'h40, 7'h40));
    msg_ready = 1'b0;
    send(8'h92); send(8'h40); send(8'h40);
    send(8'h92); send(8'h40);
    check("t6_held2", {31'd0, if2.msg_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out2", {if2.msg_valid, if2.msg_type, if2.msg_chan, if2.msg_data1, if2.msg_data2, err2, ovr2}, 0);
    check("t6_rst_out0", {if0.msg_valid, if0.msg_type, if0.msg_chan, if0.msg_data1, if0.msg_data2, err0, ovr0}, 0);
    idle(2);
    rst_n = 1'b1;
    msg_ready = 1'b1;
    idle(4);
    check("t6_after_rst2", got2.size() - s2, 1);

    // Stray data straight after reset
    snap();
    send(8'h3C); idle(2);
    check("t8_err0", err_cnt0 - e0, 1);
    check("t8_err2", err_cnt2 - e2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
